// File: rtl/feistel_lfsr_if.sv
// Block handshake bundle for feistel_lfsr_engine.
//   in_valid / in_ready / in_enc_dec / in_data    : block offered to the core
//   out_valid / out_ready / out_data              : result returned by the core
// master = host side (drives the input block and out_ready), slave = cipher core.
interface feistel_lfsr_if #(
    parameter int BLOCK_W = 64
);
    logic               in_valid;
    logic               in_ready;
    logic               in_enc_dec;
    logic [BLOCK_W-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_data;

    modport master (
        output in_valid, in_enc_dec, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_enc_dec, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/feistel_lfsr_engine.sv
// Iterative Feistel cipher core with an LFSR-derived round-key table.
// One round per clock; one block in flight; valid/ready on both sides.
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   key_load    : pulse in IDLE to regenerate the key table from key_in
//   key_in      : key seed (0 selects LFSR_SEED)
//   keys_valid  : key table complete and usable
//   busy        : core is not IDLE
//   bus         : slave side of feistel_lfsr_if (input block / result)
module feistel_lfsr_engine #(
    parameter int                   BLOCK_W   = 64,
    parameter int                   ROUNDS    = 8,
    parameter logic [BLOCK_W/2-1:0] LFSR_TAPS = 32'h8020_0003,
    parameter logic [BLOCK_W/2-1:0] LFSR_SEED = 32'hACE1_ACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_load,
    input  logic [BLOCK_W/2-1:0] key_in,
    output logic                 keys_valid,
    output logic                 busy,
    feistel_lfsr_if.slave        bus
);
    localparam int HALF_W = BLOCK_W / 2;
    localparam int RW     = $clog2(ROUNDS);
    localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, KEYGEN, RUN, HOLD} state_t;

    state_t              state, state_nxt;
    logic [HALF_W-1:0]   key_tbl [ROUNDS];
    logic [HALF_W-1:0]   lfsr;
    logic [HALF_W-1:0]   l_half, r_half;
    logic [RW-1:0]       round_cnt, kg_cnt;
    logic                mode;
    logic                out_valid_q;
    logic [BLOCK_W-1:0]  out_data_q;

    logic [RW-1:0]       key_sel;
    logic [HALF_W-1:0]   f_out, r_next, lfsr_nxt;
    logic                rc_last, kg_last, accept;

    // Galois step: shift right, fold the taps in when a 1 falls out.
    function automatic logic [HALF_W-1:0] lfsr_step(input logic [HALF_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // Round function: rotate-left-by-3 of R^K, then add K modulo 2^HALF_W.
    function automatic logic [HALF_W-1:0] round_f(input logic [HALF_W-1:0] r,
                                                   input logic [HALF_W-1:0] k);
        logic [HALF_W-1:0] x;
        x = r ^ k;
        return {x[HALF_W-4:0], x[HALF_W-1:HALF_W-3]} + k;
    endfunction

    assign rc_last  = (round_cnt == LAST);
    assign kg_last  = (kg_cnt == LAST);
    // Decryption walks the same table backwards.
    assign key_sel  = mode ? round_cnt : (LAST - round_cnt);
    assign f_out    = round_f(r_half, key_tbl[key_sel]);
    assign r_next   = l_half ^ f_out;
    assign lfsr_nxt = lfsr_step(lfsr);

    // key_load masks in_ready so a simultaneous request goes to key generation.
    assign bus.in_ready  = (state == IDLE) && keys_valid && !key_load;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (key_load)    state_nxt = KEYGEN;
                    else if (accept) state_nxt = RUN;
            KEYGEN: if (kg_last)     state_nxt = IDLE;
            RUN:    if (rc_last)     state_nxt = HOLD;
            HOLD:   if (bus.out_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_valid  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            l_half      <= '0;
            r_half      <= '0;
            round_cnt   <= '0;
            kg_cnt      <= '0;
            mode        <= 1'b0;
            lfsr        <= '0;
            for (int i = 0; i < ROUNDS; i++) key_tbl[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_load) begin
                        keys_valid <= 1'b0;
                        kg_cnt     <= '0;
                        lfsr       <= (key_in != '0) ? key_in : LFSR_SEED;
                    end else if (accept) begin
                        l_half    <= bus.in_data[BLOCK_W-1:HALF_W];
                        r_half    <= bus.in_data[HALF_W-1:0];
                        mode      <= bus.in_enc_dec;
                        round_cnt <= '0;
                    end
                end
                KEYGEN: begin
                    lfsr            <= lfsr_nxt;
                    key_tbl[kg_cnt] <= lfsr_nxt;
                    if (kg_last) keys_valid <= 1'b1;
                    else         kg_cnt     <= kg_cnt + 1'b1;
                end
                RUN: begin
                    l_half <= r_half;
                    r_half <= r_next;
                    if (rc_last) begin
                        // Output {R,L} so the last round's swap is undone.
                        out_data_q  <= {r_next, r_half};
                        out_valid_q <= 1'b1;
                    end else begin
                        round_cnt <= round_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
